// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Smallest divisor that still gives a high and a low phase.
  localparam int MIN_DIV = 2;

  // Number of clk_in cycles that clk_out is high in a period of length n.
  function automatic int unsigned hi_len(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_prog_req.sv
// Divisor request handling: validates requests, holds a pending divisor
// while the counter is mid-period and applies it on a period boundary.
//
// Handshake: div_load is a one-cycle strobe with no back-pressure. Every
// strobe is answered by either one div_err pulse (value < MIN_DIV) or,
// eventually, one div_ack pulse; repeated valid requests while busy collapse
// into a single ack carrying the last value. Busy is high while a value is
// held but not yet applied.
module clk_div_req
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_boundary,
  input  logic         i_idle,
  output logic [W-1:0] o_div_cur,
  output logic         o_busy,
  output logic         o_ack,
  output logic         o_err
);

  localparam logic [W-1:0] MIN_W = W'(MIN_DIV);

  logic [W-1:0] r_div_cur;
  logic [W-1:0] r_pend;
  logic         r_pend_v;
  logic         r_ack;
  logic         r_err;
  logic         w_valid;
  logic         w_reject;

  assign w_valid  = i_load && (i_value >= MIN_W);
  assign w_reject = i_load && (i_value <  MIN_W);

  // Capture, hold and apply divisor requests; ack/err are one-cycle pulses.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_div_cur <= W'(DEFAULT_DIV);
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= w_reject;
      if (i_idle) begin
        // Counter is stopped: no boundary to wait for.
        if (w_valid) begin
          r_div_cur <= i_value;
          r_ack     <= 1'b1;
          r_pend_v  <= 1'b0;
        end else if (r_pend_v) begin
          r_div_cur <= r_pend;
          r_ack     <= 1'b1;
          r_pend_v  <= 1'b0;
        end
      end else begin
        if (i_boundary && r_pend_v) begin
          r_div_cur <= r_pend;
          r_ack     <= 1'b1;
        end
        // A request landing on a boundary waits for the next one.
        if (w_valid) begin
          r_pend   <= i_value;
          r_pend_v <= 1'b1;
        end else if (i_boundary) begin
          r_pend_v <= 1'b0;
        end
      end
    end
  end

  assign o_div_cur = r_div_cur;
  assign o_busy    = r_pend_v;
  assign o_ack     = r_ack;
  assign o_err     = r_err;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: registered clk_out (high floor(N/2),
// low ceil(N/2) cycles), a tick strobe on each clk_out rise, and divisor
// changes that only take effect on period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         en,
  input  logic         div_load,
  input  logic [W-1:0] div_value,
  output logic         div_busy,
  output logic         div_ack,
  output logic         div_err,
  output logic         clk_out,
  output logic         tick,
  output logic         running,
  output state_t       dbg_state
);

  if ((DEFAULT_DIV < MIN_DIV) || (DEFAULT_DIV >= (2 ** W))) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV must be >= 2 and < 2**W");
  end

  localparam logic [W-1:0] ONE = W'(1);

  state_t       r_state;
  state_t       w_state_nx;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nx;
  logic [W-1:0] w_cnt_inc;
  logic [W-1:0] w_div_cur;
  logic [W-1:0] w_hi;
  logic         r_clk;
  logic         w_clk_nx;
  logic         r_tick;
  logic         w_tick_nx;
  logic         w_boundary;
  logic         w_idle;

  clk_div_req #(
    .W           (W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_req (
    .clk_in     (clk_in),
    .reset      (reset),
    .i_load     (div_load),
    .i_value    (div_value),
    .i_boundary (w_boundary),
    .i_idle     (w_idle),
    .o_div_cur  (w_div_cur),
    .o_busy     (div_busy),
    .o_ack      (div_ack),
    .o_err      (div_err)
  );

  assign w_idle     = (r_state == IDLE);
  assign w_cnt_inc  = r_cnt + ONE;
  assign w_hi       = W'(hi_len(32'(w_div_cur)));
  assign w_boundary = !w_idle && (r_cnt == (w_div_cur - ONE));

  // State, counter and output registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_clk   <= w_clk_nx;
      r_tick  <= w_tick_nx;
    end
  end

  // Next state: a started period always runs to completion; en only decides
  // whether another period follows the boundary.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    w_clk_nx   = 1'b0;
    w_tick_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nx = RUN;
          w_clk_nx   = 1'b1;
          w_tick_nx  = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (w_boundary) begin
          if (en) begin
            w_state_nx = RUN;
            w_clk_nx   = 1'b1;
            w_tick_nx  = 1'b1;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          w_cnt_nx   = w_cnt_inc;
          w_clk_nx   = (w_cnt_inc < w_hi);
          w_state_nx = en ? RUN : DRAIN;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign clk_out   = r_clk;
  assign tick      = r_tick;
  assign running   = !w_idle;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed vector table, hand-written
// corner sequences and randomized traffic, all checked against a
// period-pattern reference model.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int W = 8;

  logic         clk_in;
  logic         reset;
  logic         en;
  logic         div_load;
  logic [W-1:0] div_value;
  logic         div_busy;
  logic         div_ack;
  logic         div_err;
  logic         clk_out;
  logic         tick;
  logic         running;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  clk_div_prog #(.W(W), .DEFAULT_DIV(2)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .div_busy  (div_busy),
    .div_ack   (div_ack),
    .div_err   (div_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: a started period is a queue of clk_out values built
  // from the high/low rule; a boundary is reached when the queue runs dry.
  bit m_active;
  int m_div;
  int m_pend;
  bit m_pend_v;
  bit m_clk, m_tick, m_ack, m_err;
  bit per_q[$];

  task automatic model_reset();
    m_active = 0; m_div = 2; m_pend = 0; m_pend_v = 0;
    m_clk = 0; m_tick = 0; m_ack = 0; m_err = 0;
    per_q.delete();
  endtask

  task automatic model_step(input bit e, input bit ld, input int val);
    bit was, bnd, valid;
    was = m_active;
    bnd = was && (per_q.size() == 0);
    valid = ld && (val >= 2);
    m_ack = 0; m_tick = 0;
    m_err = ld && (val < 2);
    if (!was) begin
      if (valid) begin m_div = val; m_ack = 1; m_pend_v = 0; end
      else if (m_pend_v) begin m_div = m_pend; m_ack = 1; m_pend_v = 0; end
    end else begin
      if (bnd && m_pend_v) begin m_div = m_pend; m_ack = 1; end
      if (valid) begin m_pend = val; m_pend_v = 1; end
      else if (bnd) m_pend_v = 0;
    end
    if (was && !bnd) begin
      m_clk = per_q.pop_front();
    end else if (e) begin
      for (int k = 0; k < m_div; k++) per_q.push_back(k < (m_div / 2));
      m_clk = per_q.pop_front();
      m_tick = 1;
      m_active = 1;
    end else begin
      m_active = 0;
      m_clk = 0;
    end
  endtask

  // Scoreboard compare
  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Driver: apply inputs, advance one clk_in edge, compare on the falling edge.
  task automatic step(input logic e, input logic ld, input logic [W-1:0] val);
    en = e; div_load = ld; div_value = val;
    @(posedge clk_in);
    model_step(e, ld, int'(val));
    @(negedge clk_in);
    cycle++;
    check_bit("clk_out", clk_out, m_clk);
    check_bit("tick", tick, m_tick);
    check_bit("running", running, m_active);
    check_bit("div_busy", div_busy, m_pend_v);
    check_bit("div_ack", div_ack, m_ack);
    check_bit("div_err", div_err, m_err);
  endtask

  typedef struct {
    logic e; logic ld; logic [W-1:0] val;
    logic clk; logic tck; logic busy; logic ack; logic err; logic run;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic ld, input logic [W-1:0] val,
                              input logic c, input logic t, input logic b,
                              input logic a, input logic er, input logic r);
    vec_t v;
    v.e = e; v.ld = ld; v.val = val;
    v.clk = c; v.tck = t; v.busy = b; v.ack = a; v.err = er; v.run = r;
    return v;
  endfunction

  logic       en_r, ld_r;
  logic [W-1:0] v_r;
  int         r, acks;
  bit         exp_a[7];

  initial begin
    reset = 1'b0; en = 1'b0; div_load = 1'b0; div_value = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_bit("rst_clk_out", clk_out, 1'b0);
    check_bit("rst_tick", tick, 1'b0);
    check_bit("rst_running", running, 1'b0);
    check_bit("rst_busy", div_busy, 1'b0);
    check_bit("rst_ack", div_ack, 1'b0);
    check_bit("rst_err", div_err, 1'b0);
    reset = 1'b1;

    // Directed table: e ld val | clk tick busy ack err run
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs[0].e = 0;
    vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 1));  // N=2 start
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0));  // stop at boundary
    vecs.push_back(mk(0, 1, 5,  0, 0, 0, 1, 0, 0));  // idle load 5
    vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0,  0, 0, 0, 0, 1, 1));  // reject 0
    vecs.push_back(mk(1, 1, 1,  0, 0, 0, 0, 1, 1));  // reject 1
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 1));  // still N=5
    vecs.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 1));  // drain
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0));  // idle, no new rise
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].e, vecs[i].ld, vecs[i].val);
      check_bit("tv_clk_out", clk_out, vecs[i].clk);
      check_bit("tv_tick", tick, vecs[i].tck);
      check_bit("tv_busy", div_busy, vecs[i].busy);
      check_bit("tv_ack", div_ack, vecs[i].ack);
      check_bit("tv_err", div_err, vecs[i].err);
      check_bit("tv_running", running, vecs[i].run);
    end

    // N=4, load 3 sampled at cnt=1: period finishes as 1,1,0,0 then 1,0,0.
    step(0, 1, 4);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 3);
    check_bit("chg_busy_set", div_busy, 1'b1);
    exp_a = '{0, 1, 0, 0, 1, 0, 0};
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0);
      check_bit("chg_clk_out", clk_out, exp_a[i]);
      if (div_ack) acks++;
      if (i == 0) check_bit("chg_busy_hold", div_busy, 1'b1);
      if (i == 1) check_bit("chg_busy_clr", div_busy, 1'b0);
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL chg_ack_count got %0d expected 1", acks);
    end
    repeat (4) step(0, 0, 0);

    // N=6, en dropped at cnt=0: full period 1,1,1,0,0,0 then idle.
    step(0, 1, 6);
    step(1, 0, 0);
    exp_a = '{1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      check_bit("drain_clk_out", clk_out, exp_a[i]);
      check_bit("drain_running", running, (i < 5));
    end
    // en re-raised at cnt=3: next period follows with no gap.
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      check_bit("rearm_running", running, 1'b1);
      check_bit("rearm_tick", tick, (i == 2));
    end

    // Reset mid-period with a load pending.
    step(1, 1, 3);
    step(1, 0, 0);
    @(posedge clk_in);
    #2 reset = 1'b0;
    #1;
    check_bit("arst_clk_out", clk_out, 1'b0);
    check_bit("arst_tick", tick, 1'b0);
    check_bit("arst_running", running, 1'b0);
    check_bit("arst_busy", div_busy, 1'b0);
    check_bit("arst_ack", div_ack, 1'b0);
    check_bit("arst_err", div_err, 1'b0);
    en = 1'b0; div_load = 1'b0;
    model_reset();
    @(negedge clk_in);
    reset = 1'b1;
    step(0, 0, 0);
    check_bit("arst_no_ack", div_ack, 1'b0);
    exp_a = '{1, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      check_bit("arst_div2_clk", clk_out, exp_a[i]);
      check_bit("arst_div2_ack", div_ack, 1'b0);
    end

    // Randomized traffic against the model.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) en_r = ~en_r;
      ld_r = ($urandom_range(0, 9) == 0);
      r = int'($urandom_range(0, 15));
      if (r < 2) v_r = W'(r);
      else if (r == 15) v_r = 8'd255;
      else v_r = W'((r % 9) + 2);
      step(en_r, ld_r, v_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
